sha_seq_ctrl: RTL and testbench

SHA_SEQ_CTRL -- requirements
Module: sha_seq_ctrl

---
 rtl/sha_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_sha_seq_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_seq_ctrl.sv
// SHA-256 block sequencer: accepts 512-bit blocks, expands the message schedule,
// drives an external compression core and chains/outputs the digest.
// Optional core-timeout watchdog enabled by defining SHA_SEQ_TIMEOUT_EN.
module sha_seq_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [15:0][31:0] blk_data,
  input  logic              blk_last,
  output logic              core_reset,
  output logic [7:0][31:0]  core_H_in,
  output logic [63:0][31:0] core_W,
  input  logic              core_done,
  input  logic [7:0][31:0]  core_H_out,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic [255:0]      digest
`ifdef SHA_SEQ_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] EXPAND = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] CHAIN  = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  // Packed list: the rightmost word is H0[0].
  localparam logic [7:0][31:0] H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic [2:0]        state;
  logic [5:0]        t_cnt;
  logic              last_q;
  logic              msg_active;
  logic [7:0][31:0]  h;
  logic [63:0][31:0] w;
  logic [31:0]       w_next;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // One schedule word per EXPAND cycle; all read indices are below 16+t.
  always_comb begin
    w_next = sigma1(w[t_cnt + 6'd14]) + w[t_cnt + 6'd9]
           + sigma0(w[t_cnt + 6'd1]) + w[t_cnt];
  end

`ifdef SHA_SEQ_TIMEOUT_EN
  logic [9:0] run_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != RUN) run_cnt <= '0;
    else                       run_cnt <= run_cnt + 10'd1;
  end
`endif

  // NOTE: all state here uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      t_cnt      <= '0;
      last_q     <= 1'b0;
      msg_active <= 1'b0;
      core_reset <= 1'b1;
      // NOTE: W and H are cleared like plain registers so no stale chaining value survives reset.
      h          <= '0;
      w          <= '0;
`ifdef SHA_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            state  <= EXPAND;
            t_cnt  <= '0;
            last_q <= blk_last;
            for (int i = 0; i < 16; i++) w[i] <= blk_data[i];
            if (!msg_active) begin
              h          <= H0;
              msg_active <= 1'b1;
            end
          end
        end
        EXPAND: begin
          w[t_cnt + 6'd16] <= w_next;
          t_cnt            <= t_cnt + 6'd1;
          if (t_cnt == 6'd47) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            state <= CHAIN;
          end
`ifdef SHA_SEQ_TIMEOUT_EN
          else if (run_cnt == 10'h3ff) begin
            timeout_err <= 1'b1;
            core_reset  <= 1'b1;
            msg_active  <= 1'b0;
            state       <= IDLE;
          end
`endif
        end
        CHAIN: begin
          h          <= core_H_out;
          core_reset <= 1'b1;
          state      <= last_q ? OUT : IDLE;
        end
        OUT: begin
          if (digest_ready) begin
            msg_active <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blk_ready    = (state == IDLE);
  assign digest_valid = (state == OUT);
  assign core_H_in    = h;
  assign core_W       = w;
  assign digest       = digest_valid ? {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]}
                                     : 256'd0;

endmodule

// File: tb/tb_sha_seq_ctrl.sv
// Directed bench for sha_seq_ctrl with a behavioural SHA-256 compression core stub.
// Honours SHA_SEQ_TIMEOUT_EN to match the DUT build.
module tb_sha_seq_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic              blk_valid;
  logic              blk_ready;
  logic [15:0][31:0] blk_data;
  logic              blk_last;
  logic              core_reset;
  logic [7:0][31:0]  core_H_in;
  logic [63:0][31:0] core_W;
  logic              core_done;
  logic [7:0][31:0]  core_H_out;
  logic              digest_valid;
  logic              digest_ready;
  logic [255:0]      digest;
`ifdef SHA_SEQ_TIMEOUT_EN
  logic              timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [7:0][31:0]  h0;
  logic [15:0][31:0] abc_blk;
  logic [15:0][31:0] two_b1;
  logic [15:0][31:0] two_b2;

  sha_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .core_reset   (core_reset),
    .core_H_in    (core_H_in),
    .core_W       (core_W),
    .core_done    (core_done),
    .core_H_out   (core_H_out),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest)
`ifdef SHA_SEQ_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin,
                                                input logic [63:0][31:0] win);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [7:0][31:0] r;
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; hh = hin[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + win[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
    r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + hh;
    return r;
  endfunction

  // Core stub: finishes a few cycles after core_reset falls, holds the result until reset.
  logic             core_en;
  logic             done_force;
  logic             stub_done;
  logic [3:0]       stub_cnt;
  logic [7:0][31:0] stub_h;

  assign core_done  = stub_done | done_force;
  assign core_H_out = stub_h;

  always @(posedge clk) begin
    if (core_reset) begin
      stub_done <= 1'b0;
      stub_cnt  <= 4'd0;
    end else if (core_en && !stub_done) begin
      if (stub_cnt == 4'd4) begin
        stub_h    <= compress(core_H_in, core_W);
        stub_done <= 1'b1;
      end else begin
        stub_cnt <= stub_cnt + 4'd1;
      end
    end
  end

  task automatic send_block(input logic [15:0][31:0] d, input logic l);
    int n = 0;
    blk_data  = d;
    blk_last  = l;
    blk_valid = 1'b1;
    while (blk_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_block: blk_ready=%b after %0d cycles, required 1", blk_ready, n);
    end
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_run(output int cycles);
    cycles = 0;
    while (core_reset !== 1'b0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_run: core_reset=%b after %0d cycles, required 0", core_reset, cycles);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (blk_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle: blk_ready=%b after %0d cycles, required 1", name, blk_ready, n);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (digest_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (digest_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: digest_valid=%b after %0d cycles, required 1", name, digest_valid, n);
    end
  endtask

  task automatic wait_digest(input logic [255:0] exp, input string name);
    wait_valid(name);
    n_checks++;
    if (digest !== exp) begin
      n_fail++;
      $display("FAIL %s_digest: got %h, required %h", name, digest, exp);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    n_checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || digest !== 256'd0) begin
      n_fail++;
      $display("FAIL %s_xfer: digest_valid=%b blk_ready=%b digest=%h, required 0 1 0",
               name, digest_valid, blk_ready, digest);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (blk_ready !== 1'b1 || core_reset !== 1'b1 || digest_valid !== 1'b0 || digest !== 256'd0 ||
        core_W !== '0 || core_H_in !== '0) begin
      n_fail++;
      $display("FAIL %s: blk_ready=%b core_reset=%b digest_valid=%b digest=%h W_zero=%b H_zero=%b, required 1 1 0 0 1 1",
               name, blk_ready, core_reset, digest_valid, digest, core_W == '0, core_H_in == '0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_abc();
    int k = 0;
    send_block(abc_blk, 1'b1);
    while (core_reset !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != 48) begin
      n_fail++;
      $display("FAIL abc_latency: core_reset fell %0d cycles after acceptance, required 48", k);
    end
    n_checks++;
    if (core_W[0] !== 32'h61626380 || core_W[15] !== 32'h00000018 ||
        core_W[16] !== 32'h61626380 || core_W[17] !== 32'h000f0000) begin
      n_fail++;
      $display("FAIL abc_schedule: W0=%h W15=%h W16=%h W17=%h, required 61626380 00000018 61626380 000f0000",
               core_W[0], core_W[15], core_W[16], core_W[17]);
    end
    n_checks++;
    if (core_H_in !== h0) begin
      n_fail++;
      $display("FAIL abc_h_in: got %h, required %h", core_H_in, h0);
    end
    wait_digest(ABC_DIGEST, "abc");
  endtask

  task automatic test_two_block();
    int cyc;
    logic [7:0][31:0] first_out;
    send_block(two_b1, 1'b0);
    wait_idle("two_b1");
    n_checks++;
    if (core_reset !== 1'b1 || digest_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL two_mid: core_reset=%b digest_valid=%b, required 1 0", core_reset, digest_valid);
    end
    first_out = core_H_out;
    send_block(two_b2, 1'b1);
    wait_run(cyc);
    n_checks++;
    if (core_H_in !== first_out) begin
      n_fail++;
      $display("FAIL two_chain: core_H_in=%h, required %h", core_H_in, first_out);
    end
    wait_digest(TWO_DIGEST, "two");
  endtask

  task automatic test_done_outside_run();
    int k = 0;
    send_block(abc_blk, 1'b1);
    done_force = 1'b1;
    while (core_reset !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 10) done_force = 1'b0;
    end
    done_force = 1'b0;
    n_checks++;
    if (k != 48) begin
      n_fail++;
      $display("FAIL stray_done_latency: core_reset fell after %0d cycles, required 48", k);
    end
    wait_digest(ABC_DIGEST, "stray_done");
  endtask

  task automatic test_hold();
    send_block(abc_blk, 1'b1);
    wait_valid("hold");
    blk_data  = two_b1;
    blk_last  = 1'b0;
    blk_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (digest !== ABC_DIGEST || digest_valid !== 1'b1 || blk_ready !== 1'b0 || core_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: digest=%h valid=%b blk_ready=%b core_reset=%b, required abc 1 0 1",
                 i, digest, digest_valid, blk_ready, core_reset);
      end
    end
    blk_valid = 1'b0;
    wait_digest(ABC_DIGEST, "hold");
    @(negedge clk);
    n_checks++;
    if (core_reset !== 1'b1 || blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_no_accept: core_reset=%b blk_ready=%b, required 1 1", core_reset, blk_ready);
    end
    send_block(abc_blk, 1'b1);
    wait_digest(ABC_DIGEST, "hold_again");
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_block(abc_blk, 1'b1);
    repeat (20) @(negedge clk);
    pulse_reset();
    check_reset_state("reset_expand");
    core_en = 1'b0;
    send_block(abc_blk, 1'b1);
    wait_run(cyc);
    repeat (5) @(negedge clk);
    n_checks++;
    if (core_reset !== 1'b0 || blk_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pre_run: core_reset=%b blk_ready=%b, required 0 0", core_reset, blk_ready);
    end
    pulse_reset();
    check_reset_state("reset_run");
    core_en = 1'b1;
    send_block(two_b1, 1'b0);
    wait_idle("reset_chain");
    pulse_reset();
    send_block(abc_blk, 1'b1);
    wait_digest(ABC_DIGEST, "reset_fresh");
  endtask

  task automatic test_back_to_back();
    send_block(abc_blk, 1'b1);
    wait_digest(ABC_DIGEST, "b2b_first");
    send_block(two_b1, 1'b0);
    wait_idle("b2b_mid");
    send_block(two_b2, 1'b1);
    wait_digest(TWO_DIGEST, "b2b_second");
    send_block(abc_blk, 1'b1);
    wait_digest(ABC_DIGEST, "b2b_third");
  endtask

  task automatic test_timeout();
    int cyc;
    core_en = 1'b0;
    send_block(abc_blk, 1'b1);
    wait_run(cyc);
`ifdef SHA_SEQ_TIMEOUT_EN
    repeat (1023) @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0 || blk_ready !== 1'b0 || core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: timeout_err=%b blk_ready=%b core_reset=%b, required 0 0 0",
               timeout_err, blk_ready, core_reset);
    end
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b1 || blk_ready !== 1'b1 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: timeout_err=%b blk_ready=%b core_reset=%b, required 1 1 1",
               timeout_err, blk_ready, core_reset);
    end
    core_en = 1'b1;
    send_block(abc_blk, 1'b1);
    wait_digest(ABC_DIGEST, "timeout_recover");
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
    end
    pulse_reset();
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: timeout_err=%b, required 0", timeout_err);
    end
`else
    repeat (1100) @(negedge clk);
    n_checks++;
    if (core_reset !== 1'b0 || blk_ready !== 1'b0 || digest_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: core_reset=%b blk_ready=%b digest_valid=%b, required 0 0 0",
               core_reset, blk_ready, digest_valid);
    end
    pulse_reset();
    core_en = 1'b1;
    send_block(abc_blk, 1'b1);
    wait_digest(ABC_DIGEST, "no_timeout_recover");
`endif
  endtask

  initial begin
    h0[0] = 32'h6a09e667; h0[1] = 32'hbb67ae85; h0[2] = 32'h3c6ef372; h0[3] = 32'ha54ff53a;
    h0[4] = 32'h510e527f; h0[5] = 32'h9b05688c; h0[6] = 32'h1f83d9ab; h0[7] = 32'h5be0cd19;
    abc_blk     = '0;
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    two_b1[0]  = 32'h61626364; two_b1[1]  = 32'h62636465; two_b1[2]  = 32'h63646566; two_b1[3]  = 32'h64656667;
    two_b1[4]  = 32'h65666768; two_b1[5]  = 32'h66676869; two_b1[6]  = 32'h6768696a; two_b1[7]  = 32'h68696a6b;
    two_b1[8]  = 32'h696a6b6c; two_b1[9]  = 32'h6a6b6c6d; two_b1[10] = 32'h6b6c6d6e; two_b1[11] = 32'h6c6d6e6f;
    two_b1[12] = 32'h6d6e6f70; two_b1[13] = 32'h6e6f7071; two_b1[14] = 32'h80000000; two_b1[15] = 32'h00000000;
    two_b2      = '0;
    two_b2[15]  = 32'h000001c0;

    reset        = 1'b1;
    blk_valid    = 1'b0;
    blk_last     = 1'b0;
    blk_data     = '0;
    digest_ready = 1'b0;
    core_en      = 1'b1;
    done_force   = 1'b0;
    stub_h       = '0;

    test_reset();
    test_abc();
    test_two_block();
    test_done_outside_run();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_timeout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
